// File: rtl/conv_mac_engine.sv
// conv_mac_engine: KxK multi-channel convolution engine with kernel reuse, serial MAC,
// round/shift/saturate and a valid/ready result port.
module conv_mac_engine #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CH      = 2,
  parameter int ADDR_WIDTH  = 4,
  parameter int KADDR_WIDTH = 6,
  localparam int N         = KERNEL_SIZE * KERNEL_SIZE,
  localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(N),
  localparam int SHW       = $clog2(ACC_WIDTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_reuse_kernel,
  input  logic [SHW-1:0]               i_shift,
  output logic [KADDR_WIDTH-1:0]       o_kernel_addr,
  input  logic [DATA_WIDTH-1:0]        i_kernel_data,
  output logic [ADDR_WIDTH-1:0]        o_window_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_window_data,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_result,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_busy,
  output logic                         o_done
);
  localparam int CW = $clog2(N + 1);
  // Wide enough that the rounding constant for any shift value cannot overflow
  localparam int RW = ACC_WIDTH + (1 << SHW) + 1;
  localparam logic signed [RW-1:0] MAXV = RW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = RW'(-(1 << (DATA_WIDTH - 1)));

  typedef enum logic [2:0] {IDLE, LOAD_KERNEL, LOAD_WINDOW, MAC, ROUND, OUTPUT} state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            kvalid_q, kvalid_d;
  logic                            done_q, done_d;
  logic [SHW-1:0]                  shift_q, shift_d;
  logic signed [ACC_WIDTH-1:0]     acc_q [NUM_CH];
  logic signed [ACC_WIDTH-1:0]     acc_d [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0]    result_q, result_d;
  logic signed [DATA_WIDTH-1:0]    kern_q [N];
  logic signed [DATA_WIDTH-1:0]    win_q [NUM_CH][N];
  logic signed [2*DATA_WIDTH-1:0]  prod [NUM_CH];
  logic [CW-1:0]                   addr, cap_idx;
  logic                            last;

  function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [ACC_WIDTH-1:0] a,
                                                      input logic [SHW-1:0] s);
    logic signed [RW-1:0] v;
    v = RW'(a) + ((s == '0) ? RW'(0) : (RW'(1) << (s - 1'b1)));
    v = v >>> s;
    return (v > MAXV) ? MAXV[DATA_WIDTH-1:0] : (v < MINV) ? MINV[DATA_WIDTH-1:0] : v[DATA_WIDTH-1:0];
  endfunction

  // Address clamps at N-1 so the final capture cycle re-issues the last address
  assign addr          = (cnt_q < CW'(N - 1)) ? cnt_q : CW'(N - 1);
  assign cap_idx       = cnt_q - 1'b1;
  assign last          = cnt_q == CW'(N);
  assign o_kernel_addr = (state_q == LOAD_KERNEL) ? KADDR_WIDTH'(addr) : '0;
  assign o_window_addr = (state_q == LOAD_WINDOW) ? ADDR_WIDTH'(addr) : '0;
  assign o_valid       = state_q == OUTPUT;
  assign o_busy        = state_q != IDLE;
  assign o_done        = done_q;
  assign o_result      = result_q;

  always_ff @(posedge i_clk) begin
    if (state_q == LOAD_KERNEL && cnt_q != '0) kern_q[cap_idx] <= i_kernel_data;
    for (int c = 0; c < NUM_CH; c++)
      if (state_q == LOAD_WINDOW && cnt_q != '0) win_q[c][cap_idx] <= i_window_data[c*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kvalid_d = kvalid_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) prod[c] = win_q[c][addr] * kern_q[addr];
    case (state_q)
      IDLE: if (i_start) begin
        shift_d = i_shift;
        cnt_d   = '0;
        state_d = (i_reuse_kernel && kvalid_q) ? LOAD_WINDOW : LOAD_KERNEL;
      end
      LOAD_KERNEL: begin
        cnt_d    = last ? '0 : cnt_q + 1'b1;
        kvalid_d = kvalid_q | last;
        state_d  = last ? LOAD_WINDOW : LOAD_KERNEL;
      end
      LOAD_WINDOW: begin
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        acc_d   = '{default: '0};
        state_d = last ? MAC : LOAD_WINDOW;
      end
      MAC: begin
        for (int c = 0; c < NUM_CH; c++) acc_d[c] = acc_q[c] + ACC_WIDTH'(prod[c]);
        cnt_d   = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(N - 1)) ? ROUND : MAC;
      end
      ROUND: begin
        for (int c = 0; c < NUM_CH; c++) result_d[c*DATA_WIDTH +: DATA_WIDTH] = round_sat(acc_q[c], shift_q);
        state_d = OUTPUT;
      end
      OUTPUT: begin
        done_d  = i_ready;
        state_d = i_ready ? IDLE : OUTPUT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      kvalid_q <= 1'b0;
      done_q   <= 1'b0;
      shift_q  <= '0;
      acc_q    <= '{default: '0};
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      kvalid_q <= kvalid_d;
      done_q   <= done_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: randomized scoreboard bench with a plain-arithmetic convolution model
// and SRAM models for the kernel and window memories.
module tb_conv_mac_engine;
  localparam int N = 9, DW = 8, NC = 2, AW = 4, KAW = 6, SHW = 5;

  logic i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_reuse_kernel = 1'b0, i_ready = 1'b0;
  logic [SHW-1:0]   i_shift = '0;
  logic [KAW-1:0]   o_kernel_addr;
  logic [DW-1:0]    i_kernel_data;
  logic [AW-1:0]    o_window_addr;
  logic [NC*DW-1:0] i_window_data, o_result;
  logic             o_valid, o_busy, o_done;

  conv_mac_engine dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_reuse_kernel(i_reuse_kernel),
    .i_shift(i_shift), .o_kernel_addr(o_kernel_addr), .i_kernel_data(i_kernel_data),
    .o_window_addr(o_window_addr), .i_window_data(i_window_data), .o_result(o_result),
    .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [NC*DW-1:0] res;
    int lat;
    int kmax;
    int start_e;
  } exp_t;

  exp_t             sb[$];
  exp_t             cur;
  int               checks = 0, failures = 0, cyc = 0, kmax = 0, stall = 0;
  logic [DW-1:0]    kmem [64];
  logic [NC*DW-1:0] wmem [16];
  int               m_kern [N];
  bit               m_kvalid = 1'b0;
  bit               vprev = 1'b0, done_exp = 1'b0;

  always @(posedge i_clk) begin
    cyc           <= cyc + 1;
    i_kernel_data <= kmem[o_kernel_addr];
    i_window_data <= wmem[o_window_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard when a result appears, then tracks it until handshake
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      vprev    = 1'b0;
      done_exp = 1'b0;
    end else begin
      if (int'(o_kernel_addr) > kmax) kmax = int'(o_kernel_addr);
      chk("o_done", o_done, done_exp);
      if (done_exp) chk("valid_after_done", o_valid, 0);
      if (o_valid && !vprev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got result 0x%0h with empty scoreboard", o_result);
        end else begin
          cur = sb.pop_front();
          chk("result", o_result, cur.res);
          chk("latency", 64'(cyc - cur.start_e), 64'(cur.lat));
          chk("kernel_reads", 64'(kmax), 64'(cur.kmax));
        end
      end else if (o_valid) chk("result_stable", o_result, cur.res);
      done_exp = o_valid && i_ready;
      vprev    = o_valid;
    end
  end

  initial forever begin
    @(posedge i_clk); #1;
    if (stall > 0 && o_valid) begin
      i_ready = 1'b0;
      stall--;
    end else i_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic reset_mid();
    chk("busy_before_rst", o_busy, 1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_result", o_result, 0);
    chk("rst_kaddr", o_kernel_addr, 0);
    chk("rst_waddr", o_window_addr, 0);
    sb.delete();
    m_kvalid = 1'b0;
    i_start  = 1'b0;
    stall    = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  task automatic run_op(input bit reuse, input int sh, input int stall_n, input int rst_at);
    exp_t   e;
    bit     load;
    longint acc, v;
    load = !(reuse && m_kvalid);
    if (load) begin
      for (int t = 0; t < N; t++) m_kern[t] = $signed(kmem[t]);
      m_kvalid = 1'b1;
    end
    for (int c = 0; c < NC; c++) begin
      acc = 0;
      for (int t = 0; t < N; t++) acc += longint'($signed(wmem[t][c*DW +: DW])) * m_kern[t];
      v = acc + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0));
      v = v >>> sh;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      e.res[c*DW +: DW] = v[DW-1:0];
    end
    e.lat          = load ? 3 * N + 3 : 2 * N + 2;
    e.kmax         = load ? N - 1 : 0;
    stall          = stall_n;
    i_start        = 1'b1;
    i_reuse_kernel = reuse;
    i_shift        = SHW'(sh);
    kmax           = 0;
    e.start_e      = cyc + 1;
    sb.push_back(e);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (rst_at > 0 && cyc == e.start_e + rst_at) begin
        reset_mid();
        return;
      end
      if (o_done) begin
        i_start = 1'b0;
        return;
      end
      // Stray start pulses with scrambled side inputs while busy must be ignored
      i_start        = ($urandom_range(0, 3) == 0);
      i_reuse_kernel = 1'($urandom_range(0, 1));
      i_shift        = SHW'($urandom_range(0, 31));
      @(posedge i_clk); #1;
    end
    checks++;
    failures++;
    $display("FAIL timeout: no o_done within 200 cycles of start at edge %0d", e.start_e);
    i_start = 1'b0;
  endtask

  task automatic rand_mem();
    for (int t = 0; t < 64; t++) kmem[t] = 8'($urandom);
    for (int t = 0; t < 16; t++) wmem[t] = 16'($urandom);
  endtask

  initial begin
    for (int t = 0; t < 64; t++) kmem[t] = '0;
    for (int t = 0; t < 16; t++) wmem[t] = '0;
    #12;
    chk("reset_valid", o_valid, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_result", o_result, 0);
    chk("reset_kaddr", o_kernel_addr, 0);
    chk("reset_waddr", o_window_addr, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int t = 0; t < N; t++) begin
      kmem[t] = 8'd1;
      wmem[t] = {8'hFF, 8'(t + 1)};
    end
    run_op(0, 0, 0, 0);

    for (int t = 0; t < N; t++) begin
      kmem[t] = 8'd127;
      wmem[t] = {8'h80, 8'h7F};
    end
    run_op(0, 0, 0, 0);

    for (int t = 0; t < N; t++) begin
      kmem[t] = 8'd1;
      wmem[t] = (t == N - 1) ? {8'hFE, 8'd2} : {8'hFF, 8'd1};
    end
    run_op(0, 2, 0, 0);

    rand_mem();
    run_op(1, 1, 0, 0);
    rand_mem();
    run_op(1, 3, 5, 0);

    rand_mem();
    run_op(0, 0, 0, 24);
    rand_mem();
    run_op(1, 1, 0, 0);

    repeat (30) begin
      rand_mem();
      run_op(1'($urandom_range(0, 1)), $urandom_range(0, 12),
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0, 0);
    end
    run_op(0, 31, 0, 0);

    repeat (4) @(posedge i_clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
